input_port_debounced: RTL and testbench

- Parametrised successor to the plain 8-bit input port.
- Synchronises asynchronous external pins, debounces them as a whole word, and exposes the stable value on a read-enabled, zero-gated bus.
- Adds per-bit edge detection with a sticky, maskable interrupt status and a single interrupt line to the CPU.
- Sits between the external pins and the CPU I/O read mux / interrupt controller.

---
 rtl/input_port_debounced.sv | 88 ++++++++
 tb/tb_input_port_debounced.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/input_port_debounced.sv
// Input port with pin synchroniser, whole-word debounce, zero-gated read bus and
// sticky, maskable per-bit edge interrupts feeding a single irq line.
module input_port_debounced #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data_out,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic [1:0]       irq_mode,
   input  logic [WIDTH-1:0] irq_ack,
   output logic [WIDTH-1:0] irq_status,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] cand;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] stable;
   logic             load;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= pins_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // The stable word reloads every cycle once the count saturates; edge events
   // only fire when that reload actually changes a bit.
   always_comb begin
      load = (sync_out == cand) && (cnt == CNT_MAX);
      rise = '0;
      fall = '0;
      if (load) begin
         rise = cand & ~stable;
         fall = ~cand & stable;
      end
      ev = (({WIDTH{irq_mode[0]}} & rise) | ({WIDTH{irq_mode[1]}} & fall)) & irq_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else if (sync_out != cand) begin
         cand <= sync_out;
         cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
         stable <= cand;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A new event on a bit beats an acknowledge of the same bit in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_status <= '0;
      end else begin
         irq_status <= (irq_status & ~irq_ack) | ev;
      end
   end

   assign data_out = rd_en ? stable : '0;
   assign irq      = |irq_status;

endmodule

// File: tb/tb_input_port_debounced.sv
// Self-checking bench: a window-of-samples model of the debounced port is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_input_port_debounced;

   localparam int S   = 2;
   localparam int D   = 4;
   localparam int WIN = S + D + 1;

   logic       clk;
   logic       rst;
   logic [7:0] pins_in;
   logic       rd_en;
   logic [7:0] data_out;
   logic [7:0] irq_mask;
   logic [1:0] irq_mode;
   logic [7:0] irq_ack;
   logic [7:0] irq_status;
   logic       irq;

   int checks   = 0;
   int failures = 0;

   // Model: hist[j] holds the pin word sampled j edges ago (zero across reset).
   logic [7:0] hist [WIN];
   logic [7:0] m_stable;
   logic [7:0] m_status;

   input_port_debounced #(
      .WIDTH(8),
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pins_in(pins_in),
      .rd_en(rd_en),
      .data_out(data_out),
      .irq_mask(irq_mask),
      .irq_mode(irq_mode),
      .irq_ack(irq_ack),
      .irq_status(irq_status),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
      end
   endtask

   // The word seen D+1 edges in a row, S edges ago, becomes the stable value.
   always @(posedge clk) begin
      logic       all_same;
      logic [7:0] new_stable;
      logic [7:0] ev;
      if (rst) begin
         for (int j = 0; j < WIN; j++) hist[j] = 8'h00;
         m_stable = 8'h00;
         m_status = 8'h00;
      end else begin
         for (int j = WIN - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = pins_in;
         all_same = 1'b1;
         for (int j = S; j <= S + D; j++) begin
            if (hist[j] != hist[S]) all_same = 1'b0;
         end
         new_stable = all_same ? hist[S] : m_stable;
         ev = 8'h00;
         for (int b = 0; b < 8; b++) begin
            if (irq_mask[b] && irq_mode[0] && !m_stable[b] && new_stable[b]) ev[b] = 1'b1;
            if (irq_mask[b] && irq_mode[1] && m_stable[b] && !new_stable[b]) ev[b] = 1'b1;
         end
         m_status = (m_status & ~irq_ack) | ev;
         m_stable = new_stable;
      end
   end

   always @(posedge clk) begin
      #2;
      check_output("model_data_out", data_out, rd_en ? m_stable : 8'h00);
      check_output("model_irq_status", irq_status, m_status);
      check_output("model_irq", {7'b0, irq}, {7'b0, |m_status});
   end

   task automatic apply_stimulus(input logic [7:0] p, input logic [7:0] ack, input int cycles);
      @(negedge clk);
      pins_in = p;
      irq_ack = ack;
      repeat (cycles - 1) @(negedge clk);
   endtask

   task automatic after_edges(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   initial begin
      rst = 1'b1; pins_in = 8'h00; rd_en = 1'b0;
      irq_mask = 8'h00; irq_mode = 2'b00; irq_ack = 8'h00;
      repeat (2) @(negedge clk);
      check_output("reset_data_out", data_out, 8'h00);
      check_output("reset_irq_status", irq_status, 8'h00);
      check_output("reset_irq", {7'b0, irq}, 8'h00);
      rst = 1'b0;

      // Latency of a fresh word and read gating
      @(negedge clk);
      pins_in = 8'hA5; rd_en = 1'b1;
      after_edges(6);
      check_output("t1_edge6", data_out, 8'h00);
      after_edges(1);
      check_output("t1_edge7", data_out, 8'hA5);
      @(negedge clk);
      rd_en = 1'b0;
      #1;
      check_output("t1_rd_off", data_out, 8'h00);
      rd_en = 1'b1;

      // Short pulse is rejected
      apply_stimulus(8'h00, 8'h00, 10);
      check_output("t2_base", data_out, 8'h00);
      apply_stimulus(8'h01, 8'h00, 3);
      apply_stimulus(8'h00, 8'h00, 12);
      check_output("t2_glitch_data", data_out, 8'h00);
      check_output("t2_glitch_status", irq_status, 8'h00);

      // Rising edges, masked to the low nibble
      irq_mask = 8'h0F; irq_mode = 2'b01;
      @(negedge clk);
      pins_in = 8'hFF;
      after_edges(6);
      check_output("t3_before", irq_status, 8'h00);
      after_edges(1);
      check_output("t3_status", irq_status, 8'h0F);
      check_output("t3_irq", {7'b0, irq}, 8'h01);
      apply_stimulus(8'h00, 8'h00, 10);
      check_output("t3_fall_ignored", irq_status, 8'h0F);

      // Ack colliding with a new event on the same bit
      apply_stimulus(8'h00, 8'h0F, 1);
      apply_stimulus(8'h00, 8'h00, 1);
      irq_mask = 8'h01;
      apply_stimulus(8'h01, 8'h00, 10);
      check_output("t4_set", irq_status, 8'h01);
      apply_stimulus(8'h00, 8'h00, 10);
      @(negedge clk);
      pins_in = 8'h01;
      repeat (6) @(negedge clk);
      irq_ack = 8'h01;
      after_edges(1);
      check_output("t4_collision", irq_status, 8'h01);
      after_edges(1);
      check_output("t4_acked", irq_status, 8'h00);
      check_output("t4_irq_low", {7'b0, irq}, 8'h00);
      @(negedge clk);
      irq_ack = 8'h00;

      // Both edges on bit 7
      irq_mode = 2'b11; irq_mask = 8'h80;
      apply_stimulus(8'h81, 8'h00, 10);
      check_output("t5_rise", irq_status, 8'h80);
      apply_stimulus(8'h81, 8'h80, 1);
      apply_stimulus(8'h81, 8'h00, 2);
      check_output("t5_acked", irq_status, 8'h00);
      apply_stimulus(8'h01, 8'h00, 10);
      check_output("t5_fall", irq_status, 8'h80);
      apply_stimulus(8'h01, 8'h80, 1);

      // Edges while mode is 00 are lost
      irq_mode = 2'b00;
      apply_stimulus(8'h81, 8'h00, 10);
      irq_mode = 2'b11;
      apply_stimulus(8'h81, 8'h00, 4);
      check_output("t5_mode_off", irq_status, 8'h00);

      // Reset in the middle of a debounce
      irq_mask = 8'hFF; irq_mode = 2'b01;
      @(negedge clk);
      pins_in = 8'hFF;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("t6_in_reset", data_out, 8'h00);
      after_edges(6);
      check_output("t6_edge6_data", data_out, 8'h00);
      check_output("t6_edge6_status", irq_status, 8'h00);
      after_edges(1);
      check_output("t6_edge7_data", data_out, 8'hFF);
      check_output("t6_edge7_status", irq_status, 8'hFF);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] timeout");
   end

endmodule
